// File: rtl/train_phase_sched.sv
// Training-phase scheduler: steps one shared layer engine through forward and
// optional backward passes over all layers, repeated for a programmed iteration count.
module train_phase_sched #(
   parameter int  NUM_LAYERS = 4,
   parameter int  ITER_W     = 16,
   localparam int LAYER_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               backprop_i,
   input  logic [ITER_W-1:0]  num_iter_i,
   input  logic               abort_i,
   output logic               eng_req_o,
   input  logic               eng_ack_i,
   output logic [LAYER_W-1:0] eng_layer_o,
   output logic               eng_bwd_o,
   input  logic               eng_done_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [ITER_W-1:0]  iter_cnt_o
);

   // state    | meaning
   // IDLE     | waiting for start_i
   // FWD_REQ  | forward op on layer_q requested, waiting for eng_ack_i
   // FWD_WAIT | forward op accepted, waiting for eng_done_i
   // BWD_REQ  | backward op on layer_q requested, waiting for eng_ack_i
   // BWD_WAIT | backward op accepted, waiting for eng_done_i
   // DONE     | one-cycle completion pulse, then IDLE
   typedef enum logic [2:0] {
      IDLE, FWD_REQ, FWD_WAIT, BWD_REQ, BWD_WAIT, DONE
   } state_t;

   localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

   state_t              state_q, state_d;
   logic [LAYER_W-1:0]  layer_q, layer_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic [ITER_W-1:0]   num_iter_q, num_iter_d;
   logic                bp_q, bp_d;
   logic                iter_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         layer_q    <= '0;
         iter_q     <= '0;
         num_iter_q <= '0;
         bp_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         layer_q    <= layer_d;
         iter_q     <= iter_d;
         num_iter_q <= num_iter_d;
         bp_q       <= bp_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      layer_d    = layer_q;
      iter_d     = iter_q;
      num_iter_d = num_iter_q;
      bp_d       = bp_q;
      iter_end   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i && !abort_i) begin
               bp_d       = backprop_i;
               num_iter_d = (num_iter_i == '0) ? ITER_W'(1) : num_iter_i;
               layer_d    = '0;
               iter_d     = '0;
               state_d    = FWD_REQ;
            end
         end
         FWD_REQ: begin
            if (eng_ack_i) state_d = FWD_WAIT;
         end
         FWD_WAIT: begin
            if (eng_done_i) begin
               if (layer_q != LAST_LAYER) begin
                  layer_d = layer_q + LAYER_W'(1);
                  state_d = FWD_REQ;
               end else if (bp_q) begin
                  state_d = BWD_REQ;
               end else begin
                  iter_end = 1'b1;
               end
            end
         end
         BWD_REQ: begin
            if (eng_ack_i) state_d = BWD_WAIT;
         end
         BWD_WAIT: begin
            if (eng_done_i) begin
               if (layer_q != '0) begin
                  layer_d = layer_q - LAYER_W'(1);
                  state_d = BWD_REQ;
               end else begin
                  iter_end = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // iter_q < num_iter_q always holds, so the increment cannot overflow
      if (iter_end) begin
         if ((iter_q + ITER_W'(1)) == num_iter_q) begin
            state_d = DONE;
         end else begin
            iter_d  = iter_q + ITER_W'(1);
            layer_d = '0;
            state_d = FWD_REQ;
         end
      end

      if (abort_i && (state_q != IDLE)) begin
         state_d = IDLE;
         layer_d = layer_q;
         iter_d  = iter_q;
      end
   end

   assign eng_req_o   = (state_q == FWD_REQ) || (state_q == BWD_REQ);
   assign eng_bwd_o   = (state_q == BWD_REQ) || (state_q == BWD_WAIT);
   assign eng_layer_o = layer_q;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign iter_cnt_o  = iter_q;

endmodule

// File: tb/tb_train_phase_sched.sv
// Scoreboard bench for train_phase_sched: expected engine ops and done pulses are
// queued at start; a monitor pops and compares on every handshake and done pulse.
module tb_train_phase_sched;

   localparam int NL = 4;
   localparam int IW = 16;
   localparam int LW = 2;

   logic          clk;
   logic          rst_n;
   logic          start_i;
   logic          backprop_i;
   logic [IW-1:0] num_iter_i;
   logic          abort_i;
   logic          eng_req_o;
   logic          eng_ack_i;
   logic [LW-1:0] eng_layer_o;
   logic          eng_bwd_o;
   logic          eng_done_i;
   logic          busy_o;
   logic          done_o;
   logic [IW-1:0] iter_cnt_o;

   logic ack_m, done_m, ack_inj, done_inj;
   assign eng_ack_i  = ack_m | ack_inj;
   assign eng_done_i = done_m | done_inj;

   train_phase_sched #(.NUM_LAYERS(NL), .ITER_W(IW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .backprop_i  (backprop_i),
      .num_iter_i  (num_iter_i),
      .abort_i     (abort_i),
      .eng_req_o   (eng_req_o),
      .eng_ack_i   (eng_ack_i),
      .eng_layer_o (eng_layer_o),
      .eng_bwd_o   (eng_bwd_o),
      .eng_done_i  (eng_done_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .iter_cnt_o  (iter_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit is_done;
      bit bwd;
      int layer;
      int iter;
   } ev_t;

   ev_t q[$];
   int  total = 0;
   int  bad   = 0;
   int  run_len [NL];
   int  req_run = 0;
   int  done_dly = 0;
   bit  slow_l2 = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push_run(input bit bp, input int iters, input bit with_done);
      ev_t e;
      for (int it = 0; it < iters; it++) begin
         for (int l = 0; l < NL; l++) begin
            e = '{0, 0, l, it};
            q.push_back(e);
         end
         if (bp) begin
            for (int l = NL - 1; l >= 0; l--) begin
               e = '{0, 1, l, it};
               q.push_back(e);
            end
         end
      end
      if (with_done) begin
         e = '{1, 0, 0, iters - 1};
         q.push_back(e);
      end
   endtask

   // Engine model: ack after an optional delay, done a programmable time after ack.
   initial begin
      int ph, wcnt;
      ack_m = 0; done_m = 0; ph = 0; wcnt = 0;
      forever begin
         @(posedge clk); #1;
         case (ph)
            0: begin
               ack_m = 0; done_m = 0;
               if (eng_req_o) begin
                  wcnt = (slow_l2 && !eng_bwd_o && eng_layer_o == 2) ? 5 : 0;
                  if (wcnt == 0) begin ack_m = 1; ph = 2; end
                  else ph = 1;
               end
            end
            1: begin
               wcnt--;
               done_m = (wcnt == 3);
               if (!eng_req_o) begin done_m = 0; ph = 0; end
               else if (wcnt == 0) begin ack_m = 1; ph = 2; end
            end
            2: begin
               ack_m = 0;
               wcnt = done_dly;
               if (wcnt == 0) begin done_m = 1; ph = 0; end
               else ph = 3;
            end
            default: begin
               wcnt--;
               if (wcnt == 0) begin done_m = 1; ph = 0; end
            end
         endcase
      end
   end

   // Monitor
   initial begin
      bit prev_req, prev_ack, prev_bwd;
      int prev_layer;
      ev_t e;
      prev_req = 0; prev_ack = 0; prev_bwd = 0; prev_layer = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_req = 0; prev_ack = 0; req_run = 0;
         end else begin
            if (eng_req_o) req_run++;
            if (eng_req_o && prev_req && !prev_ack) begin
               chk("req_layer_stable", int'(eng_layer_o), prev_layer);
               chk("req_bwd_stable", int'(eng_bwd_o), int'(prev_bwd));
            end
            if (eng_req_o && eng_ack_i) begin
               if (!eng_bwd_o) run_len[eng_layer_o] = req_run;
               req_run = 0;
               if (q.size() == 0) begin
                  chk("unexpected_op_qsize", 0, 1);
               end else begin
                  e = q.pop_front();
                  chk("op_kind", 0, int'(e.is_done));
                  chk("op_layer", int'(eng_layer_o), e.layer);
                  chk("op_bwd", int'(eng_bwd_o), int'(e.bwd));
                  chk("op_iter", int'(iter_cnt_o), e.iter);
               end
            end
            if (done_o) begin
               if (q.size() == 0) begin
                  chk("unexpected_done_qsize", 0, 1);
               end else begin
                  e = q.pop_front();
                  chk("done_kind", 1, int'(e.is_done));
                  chk("done_iter", int'(iter_cnt_o), e.iter);
                  chk("done_busy", int'(busy_o), 1);
               end
            end
            prev_req   = eng_req_o;
            prev_ack   = eng_ack_i;
            prev_bwd   = eng_bwd_o;
            prev_layer = int'(eng_layer_o);
         end
      end
   end

   task automatic start_run(input bit bp, input int n);
      @(posedge clk); #2;
      start_i = 1; backprop_i = bp; num_iter_i = IW'(n);
      @(posedge clk); #2;
      start_i = 0; backprop_i = 0; num_iter_i = '0;
      @(negedge clk);
      chk("req_after_start", int'(eng_req_o), 1);
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      while (busy_o && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk("idle_within_bound", int'(busy_o), 0);
   endtask

   task automatic wait_hs(input bit bwd, input int layer, input int bound);
      bit found;
      found = 0;
      for (int i = 0; i < bound && !found; i++) begin
         @(negedge clk);
         if (eng_req_o && eng_ack_i && eng_bwd_o == bwd && int'(eng_layer_o) == layer)
            found = 1;
      end
      chk("handshake_seen", int'(found), 1);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_req"}, int'(eng_req_o), 0);
      chk({nm, "_busy"}, int'(busy_o), 0);
      chk({nm, "_done"}, int'(done_o), 0);
      chk({nm, "_layer"}, int'(eng_layer_o), 0);
      chk({nm, "_bwd"}, int'(eng_bwd_o), 0);
      chk({nm, "_iter"}, int'(iter_cnt_o), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 0; start_i = 0; backprop_i = 0; num_iter_i = '0; abort_i = 0;
      ack_inj = 0; done_inj = 0;
      for (int l = 0; l < NL; l++) run_len[l] = 0;
      repeat (3) @(posedge clk);
      #1 chk_all_zero("reset");
      #1 rst_n = 1;
      repeat (2) @(posedge clk);

      // 1: single forward-only iteration
      push_run(0, 1, 1);
      start_run(0, 1);
      wait_idle(200);
      @(negedge clk);
      chk("t1_busy_after", int'(busy_o), 0);
      chk("t1_drained", q.size(), 0);

      // 2: backprop, two iterations
      push_run(1, 2, 1);
      start_run(1, 2);
      wait_idle(400);
      chk("t2_drained", q.size(), 0);

      // 3: delayed ack on forward layer 2, early done ignored
      slow_l2 = 1;
      for (int l = 0; l < NL; l++) run_len[l] = 0;
      push_run(0, 1, 1);
      start_run(0, 1);
      wait_idle(200);
      chk("t3_req_len_l2", run_len[2], 6);
      chk("t3_req_len_l1", run_len[1], 1);
      chk("t3_drained", q.size(), 0);
      slow_l2 = 0;

      // 4: abort while in BWD_WAIT on layer 2, then restart
      done_dly = 3;
      push_run(0, 1, 0);
      begin
         ev_t e;
         e = '{0, 1, 3, 0}; q.push_back(e);
         e = '{0, 1, 2, 0}; q.push_back(e);
      end
      start_run(1, 1);
      wait_hs(1, 2, 300);
      @(posedge clk); #2 abort_i = 1;
      @(posedge clk); #2 abort_i = 0;
      @(negedge clk);
      chk("t4_busy_after_abort", int'(busy_o), 0);
      chk("t4_req_after_abort", int'(eng_req_o), 0);
      repeat (8) @(negedge clk);
      chk("t4_still_idle", int'(busy_o), 0);
      chk("t4_drained", q.size(), 0);
      done_dly = 0;
      push_run(0, 1, 1);
      start_run(0, 1);
      wait_idle(200);
      chk("t4_restart_drained", q.size(), 0);

      // 5: num_iter=0 runs once; start mid-run and stray ack/done in IDLE do nothing
      push_run(0, 1, 1);
      start_run(0, 0);
      repeat (3) @(posedge clk);
      #2 start_i = 1; backprop_i = 1; num_iter_i = IW'(5);
      @(posedge clk); #2 start_i = 0; backprop_i = 0; num_iter_i = '0;
      wait_idle(200);
      chk("t5_drained", q.size(), 0);
      @(posedge clk); #2 start_i = 1; abort_i = 1; num_iter_i = IW'(3);
      @(posedge clk); #2 start_i = 0; abort_i = 0; num_iter_i = '0;
      @(negedge clk);
      chk("t5_abort_start_busy", int'(busy_o), 0);
      @(posedge clk); #2 ack_inj = 1; done_inj = 1;
      @(posedge clk); #2 ack_inj = 0; done_inj = 0;
      @(negedge clk);
      chk("t5_stray_busy", int'(busy_o), 0);
      chk("t5_stray_req", int'(eng_req_o), 0);

      // 6: asynchronous reset during FWD_WAIT
      done_dly = 3;
      push_run(0, 1, 0);
      start_run(0, 1);
      wait_hs(0, 1, 200);
      @(posedge clk); #2 rst_n = 0;
      #1 chk_all_zero("t6_async_rst");
      q.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1;
      repeat (8) @(negedge clk);
      chk("t6_idle_busy", int'(busy_o), 0);
      chk("t6_idle_req", int'(eng_req_o), 0);
      done_dly = 0;
      push_run(0, 1, 1);
      start_run(0, 1);
      wait_idle(200);
      chk("t6_drained", q.size(), 0);

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
